control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have ports Clock (input, 1, sole clock, rising edge) and Reset (input, 1, asynchronous, active-low; 0 = reset).
REQ-002 SHALL have input IRregister (32, current instruction; opcode is IR[31:27]).
REQ-003 SHALL have input CON (1, branch condition from the datapath CON flip-flop).
REQ-004 SHALL have input Stop (1, level request to halt at the next instruction boundary).
REQ-005 SHALL have outputs HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin (1 each, register load enables).
REQ-006 SHALL have outputs HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Yout, Cout (1 each, bus drive selects).
REQ-007 SHALL have outputs Gra, Grb, Grc, Rin, Rout, BAout (1 each, register-file select and enable).
REQ-008 SHALL have outputs Read, write, IncPC (1 each, memory and PC strobes), and Run (1, high while executing).

Function
REQ-009 SHALL be a Moore FSM: every output SHALL be a pure decode of the registered state and IRregister, and SHALL be stable for the whole clock cycle of that state.
REQ-010 SHALL hold each state for exactly one clock cycle; the step sequence SHALL be T0, T1, T2, then T3 onward as the opcode requires, then return to T0.
REQ-011 Fetch steps: T0 = PCout, MARin, IncPC, Zin; T1 = Read, MDRin, ZLOout, PCin; T2 = MDRout, IRin.
REQ-012 SHALL decode the opcode from IRregister starting in T3; IRregister is valid from T3 because IRin loads on the T2 rising edge.
REQ-013 Opcodes 00011-01011 (R-type ALU): T3 = Grb, Rout, Yin; T4 = Grc, Rout, Zin; T5 = ZLOout, Gra, Rin; then T0.
REQ-014 Opcodes 01100-01110 (addi/andi/ori): T3 = Grb, Rout, Yin; T4 = Cout, Zin; T5 = ZLOout, Gra, Rin; then T0.
REQ-015 Opcode 00001 (ldi): T3 = Grb, BAout, Yin; T4 = Cout, Zin; T5 = ZLOout, Gra, Rin; then T0.
REQ-016 Opcode 00000 (ld): T3 and T4 as ldi; T5 = ZLOout, MARin; T6 = Read, MDRin; T7 = MDRout, Gra, Rin; then T0.
REQ-017 Opcode 00010 (st): T3 and T4 as ldi; T5 = ZLOout, MARin; T6 = Gra, Rout, MDRin; T7 = write; then T0.
REQ-018 Opcode 10010 (branch): T3 = Gra, Rout, CONin; T4 = PCout, Yin; T5 = Cout, Zin; T6 = ZLOout and PCin only if CON=1 (sampled in T6), otherwise no strobes; then T0.
REQ-019 Opcode 10110 (in): T3 = INPORTout, Gra, Rin. Opcode 10111 (out): T3 = Gra, Rout, OUTPORTin. Both then return to T0.
REQ-020 Opcode 11010 (nop) and every undefined opcode: T3 with no strobes asserted, then T0.
REQ-021 Opcode 11011 (halt): T3 with no strobes asserted, then Halt.
REQ-022 Halt: all strobes 0 and Run=0; the FSM SHALL leave Halt only through Reset.
REQ-023 Stop SHALL be sampled only at the end of T0's preceding instruction boundary (i.e., when the next state would be T0); if Stop=1 there, the next state SHALL be Halt. An instruction in flight always completes.
REQ-024 In every state other than Halt and reset, Run SHALL be 1.
REQ-025 At most one bus-drive output SHALL be asserted in any state.

Reset
REQ-026 Reset=0 SHALL immediately (asynchronously) force all strobe outputs to 0 and Run to 0, aborting any instruction mid-sequence.
REQ-027 The first rising Clock edge after Reset returns to 1 SHALL enter T0, with Run=1.

Verification
REQ-028 Release reset, IRregister=0x71180025 (ori R2,R3,0x25) -> T0-T5 strobes exactly as REQ-011/014, and T0 recurs at the 7th cycle.
REQ-029 ld opcode -> 8-cycle sequence; Read is high only in T1 and T6; write is never high.
REQ-030 Branch with CON=0 -> no PCin in T6; the same branch with CON=1 -> ZLOout and PCin in T6 only.
REQ-031 Assert Stop during T4 of add -> T5 completes, then Halt with Run=0 held for 20 cycles; Reset then restarts at T0.
REQ-032 Pull Reset low in T6 of st -> write never asserts, all outputs read 0 within the same cycle.
REQ-033 Each undefined opcode 11100-11111 -> one empty T3, then T0; bench checks REQ-025 in every cycle.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: multi-cycle Moore sequencer that drives the datapath strobes
// for fetch (T0-T2) and opcode-dependent execute steps (T3-T7).
module control_unit (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] IRregister,
  input  logic        CON,
  input  logic        Stop,
  output logic        HIin,
  output logic        LOin,
  output logic        PCin,
  output logic        MDRin,
  output logic        Zin,
  output logic        Yin,
  output logic        MARin,
  output logic        IRin,
  output logic        CONin,
  output logic        OUTPORTin,
  output logic        HIout,
  output logic        LOout,
  output logic        ZHIout,
  output logic        ZLOout,
  output logic        PCout,
  output logic        MDRout,
  output logic        INPORTout,
  output logic        Yout,
  output logic        Cout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Read,
  output logic        write,
  output logic        IncPC,
  output logic        Run
);

  localparam int unsigned OP_W = 5;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ALU0 = 5'b00011;
  localparam logic [OP_W-1:0] OP_ALU1 = 5'b01011;
  localparam logic [OP_W-1:0] OP_IMM0 = 5'b01100;
  localparam logic [OP_W-1:0] OP_IMM1 = 5'b01110;
  localparam logic [OP_W-1:0] OP_BR   = 5'b10010;
  localparam logic [OP_W-1:0] OP_IN   = 5'b10110;
  localparam logic [OP_W-1:0] OP_OUT  = 5'b10111;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t state, state_nxt, boundary;

  logic [OP_W-1:0] opcode;
  logic            is_alu, is_imm, is_ldi, is_ld, is_st, is_br;
  logic            unused_ir;

  assign opcode    = IRregister[31:27];
  assign unused_ir = ^IRregister[26:0];

  // Opcode classes used by the execute steps
  assign is_alu = (opcode >= OP_ALU0) && (opcode <= OP_ALU1);
  assign is_imm = (opcode >= OP_IMM0) && (opcode <= OP_IMM1);
  assign is_ldi = (opcode == OP_LDI);
  assign is_ld  = (opcode == OP_LD);
  assign is_st  = (opcode == OP_ST);
  assign is_br  = (opcode == OP_BR);

  // End of an instruction: a pending Stop diverts to Halt instead of T0
  assign boundary = Stop ? S_HALT : S_T0;

  // State register; reset parks in S_RST so every strobe drops at once
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= S_RST;
    else        state <= state_nxt;
  end

  // Next-state and strobe decode
  always_comb begin
    state_nxt = state;
    HIin = 1'b0; LOin = 1'b0; PCin = 1'b0; MDRin = 1'b0; Zin = 1'b0;
    Yin = 1'b0; MARin = 1'b0; IRin = 1'b0; CONin = 1'b0; OUTPORTin = 1'b0;
    HIout = 1'b0; LOout = 1'b0; ZHIout = 1'b0; ZLOout = 1'b0; PCout = 1'b0;
    MDRout = 1'b0; INPORTout = 1'b0; Yout = 1'b0; Cout = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    Read = 1'b0; write = 1'b0; IncPC = 1'b0;
    Run = (state != S_RST) && (state != S_HALT);

    unique case (state)
      S_RST:  state_nxt = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        state_nxt = S_T1;
      end
      S_T1: begin
        Read = 1'b1; MDRin = 1'b1; ZLOout = 1'b1; PCin = 1'b1;
        state_nxt = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_nxt = S_T3;
      end
      S_T3: begin
        state_nxt = boundary;
        if (is_alu || is_imm) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; state_nxt = S_T4;
        end else if (is_ldi || is_ld || is_st) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; state_nxt = S_T4;
        end else if (is_br) begin
          Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; state_nxt = S_T4;
        end else if (opcode == OP_IN) begin
          INPORTout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (opcode == OP_OUT) begin
          Gra = 1'b1; Rout = 1'b1; OUTPORTin = 1'b1;
        end else if (opcode == OP_HALT) begin
          state_nxt = S_HALT;
        end
      end
      S_T4: begin
        state_nxt = S_T5;
        if (is_alu) begin
          Grc = 1'b1; Rout = 1'b1; Zin = 1'b1;
        end else if (is_imm || is_ldi || is_ld || is_st) begin
          Cout = 1'b1; Zin = 1'b1;
        end else if (is_br) begin
          PCout = 1'b1; Yin = 1'b1;
        end else begin
          state_nxt = boundary;
        end
      end
      S_T5: begin
        state_nxt = boundary;
        if (is_alu || is_imm || is_ldi) begin
          ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (is_ld || is_st) begin
          ZLOout = 1'b1; MARin = 1'b1; state_nxt = S_T6;
        end else if (is_br) begin
          Cout = 1'b1; Zin = 1'b1; state_nxt = S_T6;
        end
      end
      S_T6: begin
        state_nxt = boundary;
        if (is_ld) begin
          Read = 1'b1; MDRin = 1'b1; state_nxt = S_T7;
        end else if (is_st) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; state_nxt = S_T7;
        end else if (is_br && CON) begin
          ZLOout = 1'b1; PCin = 1'b1;
        end
      end
      S_T7: begin
        state_nxt = boundary;
        if (is_ld) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (is_st) begin
          write = 1'b1;
        end
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_RST;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed per-opcode strobe sequences for control_unit.
module tb_control_unit;

  logic        Clock, Reset, CON, Stop;
  logic [31:0] IRregister;
  logic HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin;
  logic HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Yout, Cout;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Read, write, IncPC, Run;

  int total = 0;
  int bad   = 0;

  control_unit dut (
    .Clock(Clock), .Reset(Reset), .IRregister(IRregister), .CON(CON), .Stop(Stop),
    .HIin(HIin), .LOin(LOin), .PCin(PCin), .MDRin(MDRin), .Zin(Zin), .Yin(Yin),
    .MARin(MARin), .IRin(IRin), .CONin(CONin), .OUTPORTin(OUTPORTin),
    .HIout(HIout), .LOout(LOout), .ZHIout(ZHIout), .ZLOout(ZLOout), .PCout(PCout),
    .MDRout(MDRout), .INPORTout(INPORTout), .Yout(Yout), .Cout(Cout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Read(Read), .write(write), .IncPC(IncPC), .Run(Run)
  );

  // All outputs packed; bits 18..10 are the bus drivers
  logic [28:0] obs;
  assign obs = {HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin,
                HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Yout, Cout,
                Gra, Grb, Grc, Rin, Rout, BAout, Read, write, IncPC, Run};

  localparam logic [28:0] PCIN = 29'd1 << 26, MDRIN = 29'd1 << 25, ZIN = 29'd1 << 24;
  localparam logic [28:0] YIN = 29'd1 << 23, MARIN = 29'd1 << 22, IRIN = 29'd1 << 21;
  localparam logic [28:0] CONIN = 29'd1 << 20, OUTIN = 29'd1 << 19, ZLO = 29'd1 << 15;
  localparam logic [28:0] PCOUT = 29'd1 << 14, MDROUT = 29'd1 << 13, INPOUT = 29'd1 << 12;
  localparam logic [28:0] COUT = 29'd1 << 10, GRA = 29'd1 << 9, GRB = 29'd1 << 8;
  localparam logic [28:0] GRC = 29'd1 << 7, RIN = 29'd1 << 6, ROUT = 29'd1 << 5;
  localparam logic [28:0] BA = 29'd1 << 4, READ = 29'd1 << 3, WR = 29'd1 << 2;
  localparam logic [28:0] INC = 29'd1 << 1, RUN = 29'd1;
  localparam logic [28:0] F0 = PCOUT | MARIN | INC | ZIN | RUN;
  localparam logic [28:0] F1 = READ | MDRIN | ZLO | PCIN | RUN;
  localparam logic [28:0] F2 = MDROUT | IRIN | RUN;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic test_reset();
    Reset = 1'b0;
    #12;
    total++;
    if (obs !== 29'd0) begin
      bad++; $display("FAIL reset got=%h want=%h", obs, 29'd0);
    end
  endtask

  task automatic test_ori();
    logic [28:0] exp [$];
    IRregister = 32'h7118_0025;
    exp = '{F0, F1, F2, GRB | ROUT | YIN | RUN, COUT | ZIN | RUN,
            ZLO | GRA | RIN | RUN, F0};
    @(negedge Clock) Reset = 1'b1;
    for (int i = 0; i < exp.size(); i++) begin
      @(posedge Clock); #1;
      total++;
      if (obs !== exp[i]) begin bad++; $display("FAIL ori cyc%0d got=%h want=%h", i, obs, exp[i]); end
      total++;
      if ($countones(obs[18:10]) > 1) begin bad++; $display("FAIL ori_bus cyc%0d got=%h want<=1 driver", i, obs); end
    end
  endtask

  task automatic test_ld();
    logic [28:0] exp [$];
    IRregister = 32'h0000_0000;
    exp = '{F1, F2, GRB | BA | YIN | RUN, COUT | ZIN | RUN, ZLO | MARIN | RUN,
            READ | MDRIN | RUN, MDROUT | GRA | RIN | RUN, F0};
    for (int i = 0; i < exp.size(); i++) begin
      @(posedge Clock); #1;
      total++;
      if (obs !== exp[i]) begin bad++; $display("FAIL ld T%0d got=%h want=%h", i + 1, obs, exp[i]); end
      total++;
      if ($countones(obs[18:10]) > 1) begin bad++; $display("FAIL ld_bus T%0d got=%h want<=1 driver", i + 1, obs); end
    end
  endtask

  task automatic test_st_reset();
    logic [28:0] exp [$];
    IRregister = 32'h1000_0000;
    exp = '{F1, F2, GRB | BA | YIN | RUN, COUT | ZIN | RUN, ZLO | MARIN | RUN,
            GRA | ROUT | MDRIN | RUN};
    for (int i = 0; i < exp.size(); i++) begin
      @(posedge Clock); #1;
      total++;
      if (obs !== exp[i]) begin bad++; $display("FAIL st T%0d got=%h want=%h", i + 1, obs, exp[i]); end
    end
    Reset = 1'b0;
    #1;
    total++;
    if (obs !== 29'd0) begin bad++; $display("FAIL st_abort got=%h want=%h", obs, 29'd0); end
    @(posedge Clock); #1;
    total++;
    if (obs !== 29'd0) begin bad++; $display("FAIL st_held got=%h want=%h", obs, 29'd0); end
    @(negedge Clock) Reset = 1'b1;
    @(posedge Clock); #1;
    total++;
    if (obs !== F0) begin bad++; $display("FAIL st_restart got=%h want=%h", obs, F0); end
  endtask

  task automatic test_branch();
    logic [28:0] exp [$];
    IRregister = 32'h9000_0000;
    for (int c = 0; c < 2; c++) begin
      CON = (c == 1);
      exp = '{F1, F2, GRA | ROUT | CONIN | RUN, PCOUT | YIN | RUN, COUT | ZIN | RUN,
              (c == 1) ? (ZLO | PCIN | RUN) : RUN, F0};
      for (int i = 0; i < exp.size(); i++) begin
        @(posedge Clock); #1;
        total++;
        if (obs !== exp[i]) begin bad++; $display("FAIL br con%0d T%0d got=%h want=%h", c, i + 1, obs, exp[i]); end
        total++;
        if ($countones(obs[18:10]) > 1) begin bad++; $display("FAIL br_bus T%0d got=%h want<=1 driver", i + 1, obs); end
      end
    end
    CON = 1'b0;
  endtask

  task automatic test_io();
    logic [31:0] irs [2];
    logic [28:0] t3s [2];
    irs = '{32'hB000_0000, 32'hB800_0000};
    t3s = '{INPOUT | GRA | RIN | RUN, GRA | ROUT | OUTIN | RUN};
    for (int k = 0; k < 2; k++) begin
      IRregister = irs[k];
      repeat (2) @(posedge Clock);
      @(posedge Clock); #1;
      total++;
      if (obs !== t3s[k]) begin bad++; $display("FAIL io%0d T3 got=%h want=%h", k, obs, t3s[k]); end
      @(posedge Clock); #1;
      total++;
      if (obs !== F0) begin bad++; $display("FAIL io%0d back got=%h want=%h", k, obs, F0); end
    end
  endtask

  task automatic test_undefined();
    logic [4:0] ops [5];
    logic [28:0] exp [4];
    ops = '{5'b11010, 5'b11100, 5'b11101, 5'b11110, 5'b11111};
    exp = '{F1, F2, RUN, F0};
    for (int k = 0; k < 5; k++) begin
      IRregister = {ops[k], 27'd0};
      for (int i = 0; i < 4; i++) begin
        @(posedge Clock); #1;
        total++;
        if (obs !== exp[i]) begin bad++; $display("FAIL undef op%b T%0d got=%h want=%h", ops[k], i + 1, obs, exp[i]); end
        total++;
        if ($countones(obs[18:10]) > 1) begin bad++; $display("FAIL undef_bus op%b got=%h want<=1 driver", ops[k], obs); end
      end
    end
  endtask

  task automatic test_stop_halt();
    logic [28:0] exp [$];
    IRregister = 32'h1800_0000;
    exp = '{F1, F2, GRB | ROUT | YIN | RUN, GRC | ROUT | ZIN | RUN, ZLO | GRA | RIN | RUN};
    for (int i = 0; i < exp.size(); i++) begin
      @(posedge Clock); #1;
      total++;
      if (obs !== exp[i]) begin bad++; $display("FAIL add T%0d got=%h want=%h", i + 1, obs, exp[i]); end
      if (i == 3) Stop = 1'b1;
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge Clock); #1;
      total++;
      if (obs !== 29'd0) begin bad++; $display("FAIL halt cyc%0d got=%h want=%h", i, obs, 29'd0); end
    end
    Reset = 1'b0;
    Stop = 1'b0;
    @(negedge Clock) Reset = 1'b1;
    @(posedge Clock); #1;
    total++;
    if (obs !== F0) begin bad++; $display("FAIL halt_restart got=%h want=%h", obs, F0); end
  endtask

  task automatic test_halt_op();
    logic [28:0] exp [$];
    IRregister = 32'hD800_0000;
    exp = '{F1, F2, RUN, 29'd0, 29'd0, 29'd0};
    for (int i = 0; i < exp.size(); i++) begin
      @(posedge Clock); #1;
      total++;
      if (obs !== exp[i]) begin bad++; $display("FAIL haltop T%0d got=%h want=%h", i + 1, obs, exp[i]); end
    end
  endtask

  initial begin
    Reset = 1'b0;
    CON = 1'b0;
    Stop = 1'b0;
    IRregister = 32'd0;
    test_reset();
    test_ori();
    test_ld();
    test_st_reset();
    test_branch();
    test_io();
    test_undefined();
    test_stop_halt();
    test_halt_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
